// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port round-robin arbiter in front of a single-outstanding
//               line memory. Port 0 is the instruction side and port 1 is the
//               data-cache side. The winning request is latched, issued as a
//               one-cycle strobe and held stable until the memory acks.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              p0_enable_i,
  input  logic              p0_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_data_i,
  output logic              p0_ack_o,
  output logic [DATA_W-1:0] p0_data_o,

  input  logic              p1_enable_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  output logic              p1_ack_o,
  output logic [DATA_W-1:0] p1_data_o,

  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,

  output logic              busy_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_grant;       // 0 = port 0, 1 = port 1
  logic              r_last_grant;  // port served by the most recent grant
  logic              r_mem_enable;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  logic              w_any_req;
  logic              w_winner;
  logic              w_done;

  assign w_any_req = p0_enable_i | p1_enable_i;

  // Pick the winner: a lone requester wins, a tie goes to the port not served last.
  always_comb begin
    w_winner = 1'b0;
    if (p0_enable_i && p1_enable_i) begin
      w_winner = ~r_last_grant;
    end else if (p1_enable_i) begin
      w_winner = 1'b1;
    end
  end

  // Control FSM: latch the winner in IDLE, strobe in ISSUE, hold until ack in WAIT.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;   // port 0 wins the first tie after reset
      r_mem_enable <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_mem_enable <= 1'b0;
          if (w_any_req) begin
            r_state      <= S_ISSUE;
            r_grant      <= w_winner;
            r_last_grant <= w_winner;
            r_mem_enable <= 1'b1;
            r_write      <= w_winner ? p1_write_i : p0_write_i;
            r_addr       <= w_winner ? p1_addr_i  : p0_addr_i;
            r_data       <= w_winner ? p1_data_i  : p0_data_i;
          end
        end
        S_ISSUE: begin
          r_mem_enable <= 1'b0;
          r_state      <= S_WAIT;
        end
        S_WAIT: begin
          r_mem_enable <= 1'b0;
          if (mem_ack_i) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_mem_enable <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  // Memory acks only count while a transaction is outstanding; stray acks are dropped.
  assign w_done = (r_state == S_WAIT) && mem_ack_i;

  assign p0_ack_o  = w_done && !r_grant;
  assign p1_ack_o  = w_done &&  r_grant;
  assign p0_data_o = p0_ack_o ? mem_data_i : '0;
  assign p1_data_o = p1_ack_o ? mem_data_i : '0;

  assign mem_enable_o = r_mem_enable;
  assign mem_write_o  = r_write;
  assign mem_addr_o   = r_addr;
  assign mem_data_o   = r_data;

  assign busy_o = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter: directed scenarios
//               followed by randomized traffic against a transaction-level
//               round-robin reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 256;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              p0_enable_i = 1'b0, p0_write_i = 1'b0;
  logic [ADDR_W-1:0] p0_addr_i = '0;
  logic [DATA_W-1:0] p0_data_i = '0;
  logic              p0_ack_o;
  logic [DATA_W-1:0] p0_data_o;
  logic              p1_enable_i = 1'b0, p1_write_i = 1'b0;
  logic [ADDR_W-1:0] p1_addr_i = '0;
  logic [DATA_W-1:0] p1_data_i = '0;
  logic              p1_ack_o;
  logic [DATA_W-1:0] p1_data_o;
  logic              mem_enable_o, mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic [DATA_W-1:0] mem_data_i = '0;
  logic              mem_ack_i = 1'b0;
  logic              busy_o;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: which port was served last, plus pending requests.
  int                last_port;
  bit                pend   [2];
  logic              pend_w [2];
  logic [ADDR_W-1:0] pend_a [2];
  logic [DATA_W-1:0] pend_d [2];

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .p0_enable_i(p0_enable_i), .p0_write_i(p0_write_i), .p0_addr_i(p0_addr_i),
    .p0_data_i(p0_data_i), .p0_ack_o(p0_ack_o), .p0_data_o(p0_data_o),
    .p1_enable_i(p1_enable_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i),
    .p1_data_i(p1_data_i), .p1_ack_o(p1_ack_o), .p1_data_o(p1_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [DATA_W-1:0] v;
    for (int k = 0; k < DATA_W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic set_port(input int p, input logic en, input logic w,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (p == 0) begin
      p0_enable_i = en; p0_write_i = w; p0_addr_i = a; p0_data_i = d;
    end else begin
      p1_enable_i = en; p1_write_i = w; p1_addr_i = a; p1_data_i = d;
    end
  endtask

  task automatic set_en(input int p, input logic en);
    if (p == 0) p0_enable_i = en;
    else        p1_enable_i = en;
  endtask

  task automatic set_addr_data(input int p, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (p == 0) begin p0_addr_i = a; p0_data_i = d; end
    else        begin p1_addr_i = a; p1_data_i = d; end
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    p0_enable_i = 1'b0;
    p1_enable_i = 1'b0;
    mem_ack_i   = 1'b0;
    #1;
    chk("rst_outputs", {mem_enable_o, mem_write_o, p0_ack_o, p1_ack_o, busy_o}, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_data", mem_data_o, 0);
    step();
    step();
    rst_i = 1'b1;
    last_port = 1;
  endtask

  // Serve one transaction: expect port w to be issued one edge after the
  // current point, hold for lat cycles of memory latency, then ack with rd.
  task automatic serve(input int w, input logic ew, input logic [ADDR_W-1:0] ea,
                       input logic [DATA_W-1:0] ed, input int lat, input logic [DATA_W-1:0] rd,
                       input bit drop_early, input bit ack_in_issue,
                       input logic [ADDR_W-1:0] new_a, input logic [DATA_W-1:0] new_d);
    int n = 0;
    do begin step(); n++; end while (!mem_enable_o && n < 20);
    chk("issue_seen", mem_enable_o, 1);
    chk("issue_latency", n, 1);
    chk("issue_write", mem_write_o, ew);
    chk("issue_addr", mem_addr_o, ea);
    chk("issue_data", mem_data_o, ed);
    chk("issue_busy", busy_o, 1);
    set_addr_data(w, new_a, new_d);
    if (ack_in_issue) begin
      mem_ack_i  = 1'b1;
      mem_data_i = rnd_data();
      #1;
      chk("issue_ack_ignored", {p0_ack_o, p1_ack_o}, 0);
    end
    for (int i = 1; i <= lat; i++) begin
      step();
      if (drop_early && i == 1) set_en(w, 1'b0);
      mem_ack_i  = (i == lat);
      mem_data_i = (i == lat) ? rd : rnd_data();
      #1;
      chk("wait_enable_low", mem_enable_o, 0);
      chk("wait_hold_write", mem_write_o, ew);
      chk("wait_hold_addr", mem_addr_o, ea);
      chk("wait_hold_data", mem_data_o, ed);
      chk("wait_busy", busy_o, 1);
      if (i < lat) begin
        chk("wait_no_ack", {p0_ack_o, p1_ack_o}, 0);
        chk("wait_data_zero", p0_data_o | p1_data_o, 0);
      end else begin
        chk("ack_winner", w ? {p1_ack_o, p0_ack_o} : {p0_ack_o, p1_ack_o}, 2'b10);
        chk("ack_rdata", w ? p1_data_o : p0_data_o, rd);
        chk("ack_loser_data", w ? p0_data_o : p1_data_o, 0);
      end
    end
    step();
    mem_ack_i  = 1'b0;
    mem_data_i = rnd_data();
    set_en(w, 1'b0);
    #1;
    chk("post_ack_idle", busy_o, 0);
    chk("post_ack_no_ack", {p0_ack_o, p1_ack_o, mem_enable_o}, 0);
  endtask

  initial begin
    logic [DATA_W-1:0] a5, d, dd;
    logic [ADDR_W-1:0] a;
    int win;
    a5 = {(DATA_W/8){8'hA5}};

    do_reset();

    // Tie after reset: p0 first, then p1, then p0 again on a fresh tie.
    d  = rnd_data();
    dd = rnd_data();
    set_port(0, 1'b1, 1'b0, 32'h0000_1000, d);
    set_port(1, 1'b1, 1'b1, 32'h0000_2000, dd);
    serve(0, 1'b0, 32'h1000, d, 3, 256'h11, 1'b0, 1'b0, 32'h1000, d);
    serve(1, 1'b1, 32'h2000, dd, 2, 256'h22, 1'b0, 1'b0, 32'h2000, dd);
    set_port(0, 1'b1, 1'b0, 32'h0000_3000, d);
    set_port(1, 1'b1, 1'b0, 32'h0000_4000, dd);
    serve(0, 1'b0, 32'h3000, d, 1, 256'h33, 1'b0, 1'b0, 32'h3000, d);
    serve(1, 1'b0, 32'h4000, dd, 1, 256'h44, 1'b0, 1'b0, 32'h4000, dd);

    // Single p1 read, 10-cycle memory latency.
    set_port(1, 1'b1, 1'b0, 32'h0000_0400, '0);
    serve(1, 1'b0, 32'h400, '0, 10, a5, 1'b0, 1'b0, 32'h400, '0);

    // p0 write with fields held through WAIT.
    set_port(0, 1'b1, 1'b1, 32'h0000_0020, 256'h1234);
    serve(0, 1'b1, 32'h20, 256'h1234, 4, rnd_data(), 1'b0, 1'b0, 32'h20, 256'h1234);

    // Stray ack in IDLE.
    mem_ack_i  = 1'b1;
    mem_data_i = rnd_data();
    #1;
    chk("stray_no_ack", {p0_ack_o, p1_ack_o}, 0);
    step();
    mem_ack_i = 1'b0;
    #1;
    chk("stray_busy", busy_o, 0);

    // Granted p1 abandons its request in WAIT; ack still pulses.
    set_port(1, 1'b1, 1'b0, 32'h0000_0500, '0);
    serve(1, 1'b0, 32'h500, '0, 3, 256'h55, 1'b1, 1'b0, 32'h500, '0);

    // Address/data changes after the grant do not reach memory; ack in ISSUE ignored.
    d = rnd_data();
    set_port(0, 1'b1, 1'b1, 32'h0000_0040, d);
    serve(0, 1'b1, 32'h40, d, 5, 256'h66, 1'b0, 1'b1, 32'h80, rnd_data());

    // Reset asserted in WAIT aborts; the late memory ack is ignored.
    set_port(0, 1'b1, 1'b1, 32'h0000_0100, rnd_data());
    step();
    chk("rstwait_issue", mem_enable_o, 1);
    step();
    chk("rstwait_busy", busy_o, 1);
    rst_i = 1'b0;
    #1;
    chk("rstwait_outputs", {mem_enable_o, mem_write_o, busy_o, p0_ack_o, p1_ack_o}, 0);
    chk("rstwait_addr", mem_addr_o, 0);
    chk("rstwait_data", mem_data_o, 0);
    p0_enable_i = 1'b0;
    step();
    rst_i      = 1'b1;
    mem_ack_i  = 1'b1;
    mem_data_i = rnd_data();
    #1;
    chk("rstwait_late_ack", {p0_ack_o, p1_ack_o}, 0);
    chk("rstwait_late_data", p0_data_o | p1_data_o, 0);
    step();
    mem_ack_i = 1'b0;
    #1;
    chk("rstwait_idle", busy_o, 0);

    // Randomized traffic against the round-robin model.
    do_reset();
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int r = 0; r < 60; r++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom_range(0, 2) != 0)) begin
          pend[p]   = 1'b1;
          pend_w[p] = 1'($urandom_range(0, 1));
          pend_a[p] = $urandom;
          pend_d[p] = rnd_data();
          set_port(p, 1'b1, pend_w[p], pend_a[p], pend_d[p]);
        end
      end
      if (!pend[0] && !pend[1]) begin
        win       = $urandom_range(0, 1);
        pend[win]   = 1'b1;
        pend_w[win] = 1'($urandom_range(0, 1));
        pend_a[win] = $urandom;
        pend_d[win] = rnd_data();
        set_port(win, 1'b1, pend_w[win], pend_a[win], pend_d[win]);
      end
      if (pend[0] && pend[1]) win = 1 - last_port;
      else                    win = pend[0] ? 0 : 1;
      a = $urandom;
      serve(win, pend_w[win], pend_a[win], pend_d[win], $urandom_range(1, 6), rnd_data(),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), a, rnd_data());
      pend[win] = 1'b0;
      last_port = win;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
